// File: rtl/imem_access_ctrl.sv
// imem_access_ctrl: round-robin fetch/loader arbiter and fixed-window sequencer for a single-port instruction memory
module imem_access_ctrl #(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int MEM_SIZE      = 256,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_SIZE - 4);
   localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);
   state_t state, state_nx;
   logic last_ld, wr, bad, cancel, drop;
   logic [3:0] cnt;
   logic [ADDR_W-1:0] addr_q, g_addr;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic f_req, gnt_ld, gnt, legal;
   // a flush in the same cycle masks the fetch; the loader wins ties unless it won last time
   always_comb begin
      f_req  = if_req & ~if_flush;
      gnt_ld = ld_req & (~f_req | ~last_ld);
      gnt    = gnt_ld | f_req;
      g_addr = gnt_ld ? ld_addr : if_addr;
      legal  = (g_addr[1:0] == 2'b00) && (g_addr <= MAX_ADDR);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         last_ld <= 1'b0;
         wr      <= 1'b0;
         bad     <= 1'b0;
         cancel  <= 1'b0;
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state  <= state_nx;
         cancel <= (state == ACCESS) & (cancel | (if_flush & ~wr));
         if (state == IDLE) cnt <= CNT_INIT;
         else if (cnt != '0) cnt <= cnt - 4'd1;
         if (state == IDLE && gnt) begin
            last_ld <= gnt_ld;
            wr      <= gnt_ld;
            bad     <= ~legal;
            addr_q  <= g_addr;
            if (gnt_ld) wdata_q <= ld_wdata;
            if (!gnt_ld && !legal) rdata_q <= '0;
         end
         if (state == ACCESS && cnt == '0 && !wr) rdata_q <= mem_rdata;
      end
   end
   always_comb
      state_nx = state == IDLE   ? (gnt ? (legal ? ACCESS : RESP) : IDLE) :
                 state == ACCESS ? (cnt == '0 ? RESP : ACCESS) : IDLE;
   // a flush landing in the response cycle itself still drops that response
   always_comb begin
      drop      = cancel | if_flush;
      busy      = state != IDLE;
      mem_read  = (state == ACCESS) & ~wr;
      mem_write = (state == ACCESS) & wr;
      if_valid  = (state == RESP) & ~wr & ~drop;
      ld_done   = (state == RESP) & wr;
      err       = (state == RESP) & bad & (wr | ~drop);
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      if_rdata  = rdata_q;
   end
endmodule

// File: tb/tb_imem_access_ctrl.sv
// tb_imem_access_ctrl: directed stimulus against a transaction-schedule model of imem_access_ctrl
module tb_imem_access_ctrl;
   localparam int AC = 2;
   localparam int MS = 256;
   logic clk = 1'b0, rst = 1'b0;
   logic if_req = 1'b0, if_flush = 1'b0, ld_req = 1'b0;
   logic [31:0] if_addr = '0, ld_addr = '0, ld_wdata = '0;
   logic if_valid, ld_done, err, mem_read, mem_write, busy;
   logic [31:0] if_rdata, mem_addr, mem_wdata, mem_rdata;
   int n_chk = 0, n_fail = 0;
   int nrd = 0, nwr = 0, nv = 0, nd = 0;
   always #5 clk = ~clk;
   imem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_SIZE(MS), .ACCESS_CYCLES(AC)) dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_valid(if_valid), .if_rdata(if_rdata), .ld_req(ld_req), .ld_addr(ld_addr),
      .ld_wdata(ld_wdata), .ld_done(ld_done), .err(err), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
      .mem_rdata(mem_rdata), .busy(busy));
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   // power-on memory image: byte i holds i, except word 0x4 = E3A00014
   function automatic logic [7:0] init_byte(input int i);
      logic [31:0] w = 32'hE3A00014;
      return (i >= 4 && i < 8) ? w[31-8*(i-4) -: 8] : 8'(i);
   endfunction
   // physical memory, written only by DUT strobes
   logic [7:0] ram [MS];
   bit wv [MS];
   always_comb begin
      int a;
      a = int'(mem_addr[7:0]);
      mem_rdata = '0;
      if (mem_addr <= 32'd252)
         for (int k = 0; k < 4; k++) mem_rdata[31-8*k -: 8] = wv[a+k] ? ram[a+k] : init_byte(a+k);
   end
   always @(posedge clk)
      if (mem_write && mem_addr <= 32'd252)
         for (int k = 0; k < 4; k++) begin
            ram[int'(mem_addr)+k] <= mem_wdata[31-8*k -: 8];
            wv[int'(mem_addr)+k] <= 1'b1;
         end
   // reference model: one transaction record scheduled in cycle numbers
   logic [7:0] ref_mem [MS];
   bit rv [MS];
   function automatic logic [31:0] word(input logic [31:0] a);
      logic [31:0] r = '0;
      for (int k = 0; k < 4; k++) r[31-8*k -: 8] = rv[int'(a)+k] ? ref_mem[int'(a)+k] : init_byte(int'(a)+k);
      return r;
   endfunction
   int n = 0, ts = -100, tend = -100;
   bit twr = 0, tbad = 0, tcan = 0, lastl = 0, mf, mgl;
   logic [31:0] taddr = '0, tdata = '0, trd = '0, ma;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts = -100;
         tend = -100;
         tcan = 0;
         lastl = 0;
      end else begin
         n++;
         if (if_flush && !twr && n-1 >= ts && n-1 < tend) tcan = 1;
         if (n-1 > tend) begin
            mf = if_req && !if_flush;
            mgl = ld_req && (!mf || !lastl);
            if (mgl || mf) begin
               ma = mgl ? ld_addr : if_addr;
               tbad = (ma[1:0] != 2'b00) || (ma > 32'(MS-4));
               ts = n;
               tend = tbad ? n : n + AC;
               twr = mgl;
               tcan = 0;
               lastl = mgl;
               taddr = ma;
               tdata = ld_wdata;
               if (mgl && !tbad)
                  for (int k = 0; k < 4; k++) begin
                     ref_mem[int'(ma)+k] = ld_wdata[31-8*k -: 8];
                     rv[int'(ma)+k] = 1'b1;
                  end
               trd = tbad ? 32'h0 : word(ma);
            end
         end
      end
   end
   bit c_acc, c_rsp, c_bsy, c_can;
   always @(negedge clk) begin
      c_acc = !tbad && n >= ts && n < tend;
      c_rsp = n == tend;
      c_bsy = n >= ts && n <= tend;
      c_can = tcan || (if_flush && !twr);
      chk("busy", busy, c_bsy);
      chk("mem_read", mem_read, c_acc && !twr);
      chk("mem_write", mem_write, c_acc && twr);
      chk("if_valid", if_valid, c_rsp && !twr && !c_can);
      chk("ld_done", ld_done, c_rsp && twr);
      chk("err", err, c_rsp && tbad && (twr || !c_can));
      if (c_acc) chk("mem_addr", mem_addr, taddr);
      if (c_acc && twr) chk("mem_wdata", mem_wdata, tdata);
      if (c_rsp && !twr && !c_can) chk("if_rdata", if_rdata, trd);
      if (!rst) begin
         chk("rst_if_rdata", if_rdata, 32'h0);
         chk("rst_mem_addr", mem_addr, 32'h0);
         chk("rst_mem_wdata", mem_wdata, 32'h0);
      end
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      nv += int'(if_valid);
      nd += int'(ld_done);
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_resp(input string nm, output bit got_ld);
      int i;
      got_ld = 0;
      for (i = 0; i < 20; i++) begin
         tick();
         if (if_valid || ld_done) break;
      end
      if (i == 20) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: no response within 20 cycles", nm);
      end
      got_ld = ld_done;
   endtask
   task automatic wait_strobe(input string nm, input bit w);
      int i;
      for (i = 0; i < 20; i++) begin
         tick();
         if (w ? mem_write : mem_read) break;
      end
      if (i == 20) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: no strobe within 20 cycles", nm);
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      bit gl;
      logic [5:0] seq;
      int c0, c1;
      if_req = 1'b1;
      if_addr = 32'h4;
      repeat (3) tick();
      rst = 1'b1;
      wait_resp("fetch4", gl);
      chk("fetch4_data", if_rdata, 32'hE3A00014);
      chk("fetch4_err", err, 1'b0);
      chk("fetch4_read_cycles", nrd, 2);
      if_req = 1'b0;
      tick();
      rst = 1'b0;
      ld_req = 1'b1;
      ld_addr = 32'h40;
      ld_wdata = 32'hDEADBEEF;
      if_req = 1'b1;
      if_addr = 32'h10;
      repeat (2) tick();
      rst = 1'b1;
      wait_resp("cont_first", gl);
      chk("cont_loader_first", gl, 1'b1);
      ld_req = 1'b0;
      wait_resp("cont_second", gl);
      chk("cont_fetch_second", gl, 1'b0);
      if_addr = 32'h40;
      wait_resp("read40", gl);
      chk("read40_data", if_rdata, 32'hDEADBEEF);
      if_req = 1'b0;
      ld_req = 1'b1;
      ld_addr = 32'h80;
      ld_wdata = 32'h11223344;
      if_req = 1'b1;
      if_addr = 32'h84;
      seq = '0;
      for (int k = 0; k < 6; k++) begin
         wait_resp("rr", gl);
         seq = {seq[4:0], gl};
      end
      chk("rr_order", seq, 6'b101010);
      ld_req = 1'b0;
      if_req = 1'b0;
      tick();
      c0 = nrd;
      if_req = 1'b1;
      if_addr = 32'h6;
      wait_resp("ill_fetch", gl);
      chk("ill_fetch_err", err, 1'b1);
      chk("ill_fetch_rdata", if_rdata, 32'h0);
      chk("ill_fetch_no_read", nrd, c0);
      if_req = 1'b0;
      c1 = nwr;
      ld_req = 1'b1;
      ld_addr = 32'd254;
      wait_resp("ill_load", gl);
      chk("ill_load_done", gl, 1'b1);
      chk("ill_load_err", err, 1'b1);
      chk("ill_load_no_write", nwr, c1);
      ld_addr = 32'd252;
      ld_wdata = 32'hCAFEF00D;
      wait_resp("edge_load", gl);
      chk("edge_load_err", err, 1'b0);
      ld_req = 1'b0;
      if_req = 1'b1;
      if_addr = 32'h100;
      wait_resp("range_fetch", gl);
      chk("range_fetch_err", err, 1'b1);
      if_addr = 32'd252;
      wait_resp("edge_fetch", gl);
      chk("edge_fetch_data", if_rdata, 32'hCAFEF00D);
      if_addr = 32'h8;
      wait_strobe("flush_start", 1'b0);
      c0 = nrd;
      c1 = nv;
      if_flush = 1'b1;
      if_req = 1'b0;
      tick();
      if_flush = 1'b0;
      repeat (6) tick();
      chk("flush_no_valid", nv - c1, 0);
      chk("flush_read_cycles", nrd - c0, 2);
      if_req = 1'b1;
      if_addr = 32'hC;
      wait_resp("after_flush", gl);
      chk("after_flush_data", if_rdata, 32'h0C0D0E0F);
      if_req = 1'b0;
      tick();
      c0 = nd;
      ld_req = 1'b1;
      ld_addr = 32'h20;
      ld_wdata = 32'h12345678;
      wait_strobe("reset_write", 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_write", mem_write, 1'b0);
      chk("async_rst_busy", busy, 1'b0);
      repeat (2) tick();
      rst = 1'b1;
      wait_resp("rewrite", gl);
      chk("rewrite_is_load", gl, 1'b1);
      ld_req = 1'b0;
      repeat (5) tick();
      chk("rewrite_once", nd - c0, 1);
      if_req = 1'b1;
      if_addr = 32'h20;
      wait_resp("read20", gl);
      chk("read20_data", if_rdata, 32'h12345678);
      if_req = 1'b0;
      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Sequences and arbitrates the single-port, byte-addressed, big-endian instruction memory between two requesters: the IF-stage fetch port (read-only) and the program loader (write-only, boot or debug).
- Sits between the fetch stage, the loader and the instruction memory.
- Owns the mem_read/mem_write strobes, holds the address stable for a fixed access window, and returns registered responses.
- Rejects misaligned or out-of-range accesses and supports fetch flush on branch.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, instruction width (4 bytes).
- MEM_SIZE, 256, memory size in bytes; legal word addresses are 0..MEM_SIZE-4.
- ACCESS_CYCLES, 2, cycles mem_read/mem_write are held per access; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- if_req  in  1  fetch request; held until if_valid or if_flush.
- if_addr  in  ADDR_W  fetch byte address.
- if_flush  in  1  one-cycle pulse; cancels the pending or in-flight fetch.
- if_valid  out  1  one-cycle pulse; if_rdata/err valid.
- if_rdata  out  DATA_W  fetched instruction.
- ld_req  in  1  loader write request; held until ld_done.
- ld_addr  in  ADDR_W  write byte address.
- ld_wdata  in  DATA_W  write data.
- ld_done  out  1  one-cycle pulse; write complete or rejected.
- err  out  1  qualifies if_valid/ld_done: access rejected.
- mem_addr  out  ADDR_W  address to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_rdata  in  DATA_W  read data from memory (combinational).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; last_grant=FETCH; cnt=0; cancel=0.
  - Zeroed outputs: if_valid, ld_done, err, mem_read, mem_write, busy, if_rdata, mem_addr, mem_wdata.
  - Reset mid-access aborts with no response; requesters re-issue.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Sample requests (if_req masked by if_flush in the same cycle).
  - If only one requests, grant it. If both request, grant the one not in last_grant (round-robin), so the loader wins first after reset. Update last_grant.
  - On grant, register addr/wdata/direction. Legality check: addr[1:0]==0 and addr <= MEM_SIZE-4.
  - Legal grant → ACCESS, cnt=ACCESS_CYCLES-1.
  - Illegal grant → RESP with bad=1 and no memory strobe.
- ACCESS:
  - mem_addr/mem_wdata are driven from the captured registers, stable for the whole window.
  - mem_read (fetch) or mem_write (loader) is high for exactly ACCESS_CYCLES consecutive cycles.
  - cnt decrements each cycle. On the cycle with cnt==0, capture mem_rdata into if_rdata (fetch only), then → RESP.
- RESP (one cycle):
  - Pulse if_valid or ld_done; err=bad.
  - On a rejected fetch, if_rdata=0.
  - If cancel=1, suppress if_valid and err (the access still completed).
  - Then → IDLE. Strobes are low in RESP and IDLE.
- if_flush:
  - In IDLE: drops the fetch request that cycle.
  - While a fetch is in ACCESS/RESP: sets cancel. The memory access is not truncated (the window stays fixed), only the response is dropped.
  - No effect on loader transactions.
  - cancel clears on return to IDLE.
- Latency: request seen in IDLE at edge T → strobes in cycles T+1..T+ACCESS_CYCLES → response pulse in cycle T+ACCESS_CYCLES+1. Minimum request-to-request spacing is ACCESS_CYCLES+2.
- New requests are ignored while busy; requesters hold req. A requester deasserting req before its response is protocol misuse; the transaction completes regardless.
- Data ordering: byte at addr = bits [31:24] (big-endian), matching the memory.

Test Plan:
- Reset then fetch: rst low 3 cycles, if_req=1, if_addr=0x4 (mem holds 0xE3A00014), ACCESS_CYCLES=2 → mem_read high 2 cycles with mem_addr=0x4; if_valid pulse 3 cycles after grant; if_rdata=0xE3A00014; err=0.
- Contention: if_req and ld_req both high from reset release → loader granted first (mem_write, addr 0x40, wdata 0xDEADBEEF, ld_done); fetch granted next; a subsequent fetch of 0x40 returns 0xDEADBEEF.
- Round-robin fairness: both requesters held high for 6 transactions → grants alternate L,F,L,F,L,F; no strobe overlap; busy low exactly one cycle between each.
- Illegal access: if_addr=0x6 → no mem_read; next cycle if_valid=1, err=1, if_rdata=0. ld_addr=MEM_SIZE-2 (254) → ld_done=1, err=1, no mem_write.
- Flush in flight: fetch 0x8 granted, if_flush pulse in first ACCESS cycle → mem_read still held 2 cycles; no if_valid pulse; the next fetch (0xC) completes normally.
- Async reset mid-access: assert rst during ACCESS of a write → mem_write drops immediately, state=IDLE; no ld_done; after release the loader re-request completes once.
